vga_timing_pipe: RTL and testbench
==================================

Name: vga_timing_pipe

Overview:
- Parametrised VGA timing generator and output stage for the Tiny Tapeout demo designs.
- Produces horizontal/vertical counters, line/frame strobes and sync signals. Any resolution, porch set, sync polarity and colour depth is selected by parameter.
- Delays sync and blanking by a configurable pipeline depth so they align with a renderer that returns colour several cycles after the coordinates are issued.
- Sits between the renderer core and the TinyVGA PMOD pin mapping.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in clocks
- H_SYNC, 96, horizontal sync width in clocks
- H_BACK, 48, horizontal back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- HSYNC_POL, 0, active level of hsync_o (0 = active low)
- VSYNC_POL, 0, active level of vsync_o
- COLOR_BITS, 2, bits per colour channel
- PIPE_DELAY, 1, renderer latency in clocks from x_o/y_o to color_i; range 0..8

Ports:
- clk_i  input  1  pixel clock
- rst_ni  input  1  asynchronous active-low reset
- x_o  output  $clog2(H_TOTAL)  current horizontal counter; H_TOTAL = sum of the four H parameters
- y_o  output  $clog2(V_TOTAL)  current vertical counter; V_TOTAL = sum of the four V parameters
- active_o  output  1  counters are inside the visible area (undelayed)
- next_vertical_o  output  1  one-cycle strobe on the last clock of each line (undelayed)
- next_frame_o  output  1  one-cycle strobe on the last clock of each frame (undelayed)
- color_i  input  3*COLOR_BITS  renderer colour, packed {R,G,B}; valid PIPE_DELAY clocks after the matching x_o/y_o
- rgb_o  output  3*COLOR_BITS  registered colour to pins; zero while blanked
- hsync_o  output  1  registered, delayed hsync
- vsync_o  output  1  registered, delayed vsync

Behaviour:
- Reset (async assert, clocked release):
  - x_o=0, y_o=0, next_vertical_o=0, next_frame_o=0, rgb_o=0.
  - hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL.
  - All delay-line stages hold blank with inactive syncs.
  - active_o=1 combinationally, because (0,0) is visible.
- Horizontal counter:
  - x increments every clock.
  - x==H_TOTAL-1 wraps to 0.
  - On that wrap, y increments; y==V_TOTAL-1 wraps to 0.
- Decodes from the undelayed counters:
  - active = (x<H_ACTIVE) && (y<V_ACTIVE).
  - hs_raw asserted for H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC.
  - vs_raw asserted for V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC, for whole lines.
  - Vsync edges coincide with the clock where x wraps to 0.
- Strobes:
  - next_vertical_o = (x==H_TOTAL-1).
  - next_frame_o = next_vertical_o && (y==V_TOTAL-1).
  - Both are combinational from registered counters and are high for exactly one clock.
- Delay line:
  - {active, hs_raw, vs_raw} pass through a PIPE_DELAY-stage shift register.
  - PIPE_DELAY=0 means no stages.
- Output register (one stage, always present):
  - rgb_o <= delayed_active ? color_i : 0.
  - hsync_o <= delayed_hs ^ ~HSYNC_POL.
  - vsync_o <= delayed_vs ^ ~VSYNC_POL.
- Total latency from counter value to pins is PIPE_DELAY+1 clocks. The colour for pixel (x,y) appears on rgb_o in the same cycle as the sync/blank state of (x,y).
- Width rules:
  - Counters are sized by $clog2 of the totals.
  - Comparisons are unsigned.
  - Totals need not be powers of two.
  - No counter ever reaches H_TOTAL or V_TOTAL.
- Reset mid-frame: counters and delay line clear immediately. The first frame after release starts at (0,0) with full blanking history; there are no spurious sync pulses.
- color_i is ignored (rgb_o forced 0) whenever the delayed active bit is 0, including the first PIPE_DELAY+1 clocks after reset, where the delay line holds blank.

Test Plan:
- Reset, defaults:
  - Hold rst_ni=0 for 5 clocks with color_i=6'h3F. Required: rgb_o=0, hsync_o=1, vsync_o=1, x_o=0, y_o=0, strobes 0, changing asynchronously with reset assertion.
  - Release reset and drive color_i=6'h3F. Required: rgb_o becomes 6'h3F at the (PIPE_DELAY+1)-th clock edge after release.
- Line timing, defaults, PIPE_DELAY=1:
  - hsync_o low for exactly 96 clocks per 800-clock line.
  - Falling edge 2 clocks after x_o==656.
  - next_vertical_o pulses when x_o==799, every 800 clocks.
- Frame timing, defaults:
  - next_frame_o pulses once per 800*525=420000 clocks, at x_o=799, y_o=524.
  - vsync_o low for exactly 1600 clocks, starting 2 clocks after (x_o=0, y_o=490).
- Pipeline alignment, PIPE_DELAY=3, COLOR_BITS=2:
  - Model renderer returns color_i = x[5:0] delayed 3 clocks.
  - Required: rgb_o == (x mod 64) of the pixel being displayed for every active pixel, and 0 during all 160 blank clocks of each line.
- Small configuration:
  - H=8/2/2/2, V=4/1/1/1, PIPE_DELAY=0, HSYNC_POL=1, VSYNC_POL=1.
  - x_o wraps at 13, y_o wraps at 6.
  - hsync_o is high at the 2 clocks following x_o=10 and 11.
  - vsync_o is high for line 5 only, shifted 1 clock.
  - next_frame_o period is 98 clocks.
- Mid-frame reset:
  - Assert rst_ni=0 at y_o=200, x_o=300 for 2 clocks.
  - Required: outputs return to reset values immediately.
  - After release, x_o/y_o restart at 0 and first next_frame_o occurs exactly 420000 clocks later.
  - No sync glitch occurs.

Source files
------------

// File: rtl/vga_timing_pipe_if.sv
// Bus between the VGA timing stage, the renderer core and the PMOD pin mapping.
// The master side is the timing generator and the slave side is the renderer or pins.
interface vga_timing_pipe_if #(
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int COLOR_BITS = 2
);
    logic [X_W-1:0]          x_o;
    logic [Y_W-1:0]          y_o;
    logic                    active_o;
    logic                    next_vertical_o;
    logic                    next_frame_o;
    logic [3*COLOR_BITS-1:0] color_i;
    logic [3*COLOR_BITS-1:0] rgb_o;
    logic                    hsync_o;
    logic                    vsync_o;

    modport master (
        output x_o, y_o, active_o, next_vertical_o, next_frame_o,
        output rgb_o, hsync_o, vsync_o,
        input  color_i
    );

    modport slave (
        input  x_o, y_o, active_o, next_vertical_o, next_frame_o,
        input  rgb_o, hsync_o, vsync_o,
        output color_i
    );
endinterface

// File: rtl/vga_timing_pipe.sv
// VGA timing generator with a sync/blank delay line that lines up with a renderer of fixed
// latency, followed by one registered output stage that drives the pins.
module vga_timing_pipe #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int COLOR_BITS = 2,
    parameter int PIPE_DELAY = 1
) (
    input logic               clk_i,
    input logic               rst_ni,
    vga_timing_pipe_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int X_W     = $clog2(H_TOTAL);
    localparam int Y_W     = $clog2(V_TOTAL);

    localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FRONT);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FRONT);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic           HS_ACT   = (HSYNC_POL != 0);
    localparam logic           VS_ACT   = (VSYNC_POL != 0);

    logic [X_W-1:0]          x_q;
    logic [Y_W-1:0]          y_q;
    logic                    active;
    logic                    hs_raw;
    logic                    vs_raw;
    logic                    line_end;
    logic [2:0]              raw_bits;
    logic [2:0]              delayed;
    logic [3*COLOR_BITS-1:0] rgb_q;
    logic                    hsync_q;
    logic                    vsync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else if (line_end) begin
            x_q <= '0;
            y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
            x_q <= x_q + 1'b1;
        end
    end

    assign line_end = (x_q == X_LAST);
    assign active   = (x_q < X_ACT) && (y_q < Y_ACT);
    assign hs_raw   = (x_q >= HS_START) && (x_q < HS_END);
    assign vs_raw   = (y_q >= VS_START) && (y_q < VS_END);
    assign raw_bits = {active, hs_raw, vs_raw};

    // Each stage resets to blank with idle syncs, so nothing leaks out right after reset.
    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign delayed = raw_bits;
        end else begin : g_pipe
            logic [2:0] stage [PIPE_DELAY];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= raw_bits;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign delayed = stage[PIPE_DELAY-1];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_q   <= '0;
            hsync_q <= ~HS_ACT;
            vsync_q <= ~VS_ACT;
        end else begin
            rgb_q   <= delayed[2] ? vga.color_i : '0;
            hsync_q <= delayed[1] ? HS_ACT : ~HS_ACT;
            vsync_q <= delayed[0] ? VS_ACT : ~VS_ACT;
        end
    end

    assign vga.x_o             = x_q;
    assign vga.y_o             = y_q;
    assign vga.active_o        = active;
    assign vga.next_vertical_o = line_end;
    assign vga.next_frame_o    = line_end && (y_q == Y_LAST);
    assign vga.rgb_o           = rgb_q;
    assign vga.hsync_o         = hsync_q;
    assign vga.vsync_o         = vsync_q;
endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench for vga_timing_pipe: a tiny active-high configuration checked from a vector
// table, plus full-width 800-clock lines (short frames) checked every cycle against cycle-count math.
module tb_vga_timing_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;
    int   cyc;
    int   tests    = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Tiny: 14x7 frame, no renderer delay, active-high syncs.
    vga_timing_pipe_if #(.X_W(4), .Y_W(3), .COLOR_BITS(2)) bus_small ();
    // Default 800-clock lines with an 8-line frame (4/1/2/1) to keep run time short.
    vga_timing_pipe_if #(.X_W(10), .Y_W(3), .COLOR_BITS(2)) bus_def ();
    vga_timing_pipe_if #(.X_W(10), .Y_W(3), .COLOR_BITS(2)) bus_pipe ();

    vga_timing_pipe #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .COLOR_BITS(2), .PIPE_DELAY(0)
    ) u_small (.clk_i(clk), .rst_ni(rst_n), .vga(bus_small));

    vga_timing_pipe #(
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIPE_DELAY(1)
    ) u_def (.clk_i(clk), .rst_ni(rst_n), .vga(bus_def));

    vga_timing_pipe #(
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIPE_DELAY(3)
    ) u_pipe (.clk_i(clk), .rst_ni(rst_n), .vga(bus_pipe));

    // Renderer model: returns x[5:0] three clocks after the coordinate is issued.
    logic [9:0] hist [3];
    always @(posedge clk) begin
        hist[0] <= bus_pipe.x_o;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
    end
    assign bus_pipe.color_i = hist[2][5:0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int         cycle;
        logic [5:0] color;
        int         x;
        int         y;
        logic       active;
        logic       nv;
        logic       nf;
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
    } vec_t;

    vec_t vecs [16];

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus_small.color_i = v.color;
        while (cyc < v.cycle) @(negedge clk);
    endtask

    task automatic checkVector(input int i, input vec_t v);
        checkOutput($sformatf("vec%0d_x", i),      int'(bus_small.x_o), v.x);
        checkOutput($sformatf("vec%0d_y", i),      int'(bus_small.y_o), v.y);
        checkOutput($sformatf("vec%0d_active", i), int'(bus_small.active_o), int'(v.active));
        checkOutput($sformatf("vec%0d_nv", i),     int'(bus_small.next_vertical_o), int'(v.nv));
        checkOutput($sformatf("vec%0d_nf", i),     int'(bus_small.next_frame_o), int'(v.nf));
        checkOutput($sformatf("vec%0d_rgb", i),    int'(bus_small.rgb_o), int'(v.rgb));
        checkOutput($sformatf("vec%0d_hs", i),     int'(bus_small.hsync_o), int'(v.hs));
        checkOutput($sformatf("vec%0d_vs", i),     int'(bus_small.vsync_o), int'(v.vs));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_small_x"},   int'(bus_small.x_o), 0);
        checkOutput({tag, "_small_y"},   int'(bus_small.y_o), 0);
        checkOutput({tag, "_small_rgb"}, int'(bus_small.rgb_o), 0);
        checkOutput({tag, "_small_hs"},  int'(bus_small.hsync_o), 0);
        checkOutput({tag, "_small_vs"},  int'(bus_small.vsync_o), 0);
        checkOutput({tag, "_def_x"},     int'(bus_def.x_o), 0);
        checkOutput({tag, "_def_y"},     int'(bus_def.y_o), 0);
        checkOutput({tag, "_def_act"},   int'(bus_def.active_o), 1);
        checkOutput({tag, "_def_nv"},    int'(bus_def.next_vertical_o), 0);
        checkOutput({tag, "_def_nf"},    int'(bus_def.next_frame_o), 0);
        checkOutput({tag, "_def_rgb"},   int'(bus_def.rgb_o), 0);
        checkOutput({tag, "_def_hs"},    int'(bus_def.hsync_o), 1);
        checkOutput({tag, "_def_vs"},    int'(bus_def.vsync_o), 1);
        checkOutput({tag, "_pipe_rgb"},  int'(bus_pipe.rgb_o), 0);
        checkOutput({tag, "_pipe_hs"},   int'(bus_pipe.hsync_o), 1);
    endtask

    // Every cycle, outputs of the 800-clock instances must match pixel (cyc - latency).
    always @(negedge clk) begin : per_cycle
        int c, ex, ey, p, px, py;
        logic vis;
        if (chk_en && rst_n) begin
            c  = cyc % 6400;
            ex = c % 800;
            ey = c / 800;
            checkOutput("def_x",  int'(bus_def.x_o), ex);
            checkOutput("def_y",  int'(bus_def.y_o), ey);
            checkOutput("def_active", int'(bus_def.active_o), int'(ex < 640 && ey < 4));
            checkOutput("def_nv", int'(bus_def.next_vertical_o), int'(ex == 799));
            checkOutput("def_nf", int'(bus_def.next_frame_o), int'(ex == 799 && ey == 7));

            p = cyc - 2;
            px = (p < 0) ? 0 : (p % 6400) % 800;
            py = (p < 0) ? 0 : (p % 6400) / 800;
            vis = (p >= 0) && px < 640 && py < 4;
            checkOutput("def_rgb", int'(bus_def.rgb_o), vis ? 63 : 0);
            checkOutput("def_hs",  int'(bus_def.hsync_o), int'(!(p >= 0 && px >= 656 && px < 752)));
            checkOutput("def_vs",  int'(bus_def.vsync_o), int'(!(p >= 0 && (py == 5 || py == 6))));

            p = cyc - 4;
            px = (p < 0) ? 0 : (p % 6400) % 800;
            py = (p < 0) ? 0 : (p % 6400) / 800;
            vis = (p >= 0) && px < 640 && py < 4;
            checkOutput("pipe_rgb", int'(bus_pipe.rgb_o), vis ? (px % 64) : 0);
            checkOutput("pipe_hs",  int'(bus_pipe.hsync_o), int'(!(p >= 0 && px >= 656 && px < 752)));
            checkOutput("pipe_vs",  int'(bus_pipe.vsync_o), int'(!(p >= 0 && (py == 5 || py == 6))));
        end
    end

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t1, t2, cnt, n;
        logic found;

        vecs = '{
            '{0,   6'h3F, 0,  0, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0},
            '{1,   6'h3F, 1,  0, 1'b1, 1'b0, 1'b0, 6'h3F, 1'b0, 1'b0},
            '{10,  6'h3F, 10, 0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0},
            '{11,  6'h3F, 11, 0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0},
            '{12,  6'h3F, 12, 0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0},
            '{13,  6'h3F, 13, 0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0},
            '{14,  6'h3F, 0,  1, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0},
            '{15,  6'h2A, 1,  1, 1'b1, 1'b0, 1'b0, 6'h2A, 1'b0, 1'b0},
            '{56,  6'h2A, 0,  4, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0},
            '{71,  6'h2A, 1,  5, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1},
            '{84,  6'h2A, 0,  6, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1},
            '{85,  6'h2A, 1,  6, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0},
            '{97,  6'h2A, 13, 6, 1'b0, 1'b1, 1'b1, 6'h00, 1'b0, 1'b0},
            '{98,  6'h15, 0,  0, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0},
            '{99,  6'h15, 1,  0, 1'b1, 1'b0, 1'b0, 6'h15, 1'b0, 1'b0},
            '{109, 6'h15, 11, 0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0}
        };

        bus_small.color_i = 6'h3F;
        bus_def.color_i   = 6'h3F;

        // Reset must take effect before any clock edge arrives.
        #2 rst_n = 1'b0;
        #1 checkResetValues("rst_async");
        repeat (5) @(negedge clk);
        checkResetValues("rst_hold");

        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        $display("[TB] reset released, running vector table");

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        // Tiny frame: next_frame_o period of 98 clocks.
        found = 1'b0;
        for (n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            found = (bus_small.next_frame_o === 1'b1);
        end
        t1 = cyc;
        checkOutput("small_nf_first", t1, 195);
        @(negedge clk);
        found = 1'b0;
        for (n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            found = (bus_small.next_frame_o === 1'b1);
        end
        t2 = cyc;
        checkOutput("small_nf_period", t2 - t1, 98);

        // Sync widths over one full line and one full frame.
        cnt = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (bus_def.hsync_o === 1'b0) cnt++;
        end
        checkOutput("def_hsync_low_per_line", cnt, 96);
        cnt = 0;
        for (int i = 0; i < 6400; i++) begin
            @(negedge clk);
            if (bus_def.vsync_o === 1'b0) cnt++;
        end
        checkOutput("def_vsync_low_per_frame", cnt, 1600);

        // Mid-frame reset at (300, 2).
        found = 1'b0;
        for (n = 0; n < 7000 && !found; n++) begin
            @(negedge clk);
            found = (bus_def.x_o == 10'd300 && bus_def.y_o == 3'd2);
        end
        checkOutput("midreset_reached", int'(found), 1);
        #2 rst_n = 1'b0;
        chk_en = 1'b0;
        #1 checkResetValues("midrst_async");
        repeat (2) @(negedge clk);
        checkResetValues("midrst_hold");
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        found = 1'b0;
        for (n = 0; n < 7000 && !found; n++) begin
            found = (bus_def.next_frame_o === 1'b1);
            if (!found) @(negedge clk);
        end
        checkOutput("first_nf_after_reset", cyc, 6399);

        repeat (20) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
